grant_decoder: RTL and testbench
================================

Name: grant_decoder

Overview:
- Sequential 2-to-4 index decoder; consumes the {index, zero} pair produced by the team's priority encoder and drives a registered one-hot grant back to the requesting line.
- Each grant is held until the granted line signals done, or until a hold timeout expires.
- Valid/ready handshake on the input side, so the encoder side can be stalled while a grant is outstanding.

Parameters:
- N_OUT, 4, number of grant lines; power of two, >= 2.
- IDX_W, 2, index width; must equal log2(N_OUT).
- HOLD_MAX, 15, maximum cycles a grant is held without done; range 1..2^CNT_W-1.
- CNT_W, 4, hold counter width.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  encoder output is valid this cycle.
- in_ready  output  1  block can accept; high only in IDLE.
- in_idx  input  IDX_W  encoded index of the highest-priority request.
- in_zero  input  1  no request active; in_idx is don't-care when high.
- done  input  1  granted line finished; sampled only in GRANT.
- grant  output  N_OUT  registered one-hot grant; all-zero when idle.
- grant_valid  output  1  registered; high whenever grant is non-zero.
- none_pulse  output  1  registered one-cycle pulse: a zero (no-request) word was accepted.
- timeout  output  1  registered one-cycle pulse: grant released by hold expiry.

Behaviour:
- Reset (async, rst=1): state=IDLE; grant=0, grant_valid=0, none_pulse=0, timeout=0, hold counter=0. in_ready goes to 1 immediately, since it is decoded from the state.
- Accept: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
- in_ready: combinational from state, with no dependence on in_valid.
- States: IDLE, GRANT.
- IDLE, accept with in_zero=1:
  - Stay in IDLE; grant stays 0.
  - none_pulse=1 for exactly the next cycle.
  - in_idx is ignored, including X/Z values.
- IDLE, accept with in_zero=0:
  - grant <= 1 << in_idx and grant_valid <= 1; counter <= 0; go to GRANT.
  - Latency: grant is visible in the cycle immediately after the accepting edge.
- IDLE, no accept: all outputs hold at 0; pulses are deasserted.
- GRANT:
  - in_ready=0; grant is held constant; counter increments by 1 every cycle.
  - Exit on done=1: grant <= 0, grant_valid <= 0, go to IDLE; no timeout.
  - Exit on done=0 with counter == HOLD_MAX-1: grant <= 0, timeout=1 for one cycle, go to IDLE.
  - Maximum grant duration is therefore exactly HOLD_MAX cycles.
  - done and expiry in the same cycle: done wins and timeout stays 0.
- done in IDLE: ignored.
- Throughput: at least one IDLE cycle between consecutive grants. Back-to-back grants to the same line are permitted.
- Counter: never wraps, because expiry exits GRANT first. Width: CNT_W must satisfy HOLD_MAX-1 < 2^CNT_W (elaboration-time check).
- Reset mid-GRANT: grant drops asynchronously; no timeout pulse is generated. After release, the block accepts on the next edge.
- Invariant: grant is one-hot or zero at every cycle, and grant_valid == |grant.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, GRANT=1'b1) and default constants N_OUT=4 and HOLD_MAX=15.
- One sub-module, onehot_dec: combinational IDX_W-to-N_OUT decoder with an enable input. It is reused elsewhere; the top level registers its output.
- The FSM, counter and pulse generation stay in the top level.

Test Plan:
- Reset: hold rst=1 mid-cycle -> grant=4'b0000, in_ready=1, timeout=0 asynchronously; release, then idle for 5 cycles -> outputs stay 0.
- Decode all: for idx 0..3, apply in_valid=1, in_zero=0, then done on the 3rd GRANT cycle:
  - grant is 0001/0010/0100/1000 the cycle after accept and held for 3 cycles;
  - in_ready=0 throughout GRANT;
  - timeout never asserts.
- Zero word: in_valid=1, in_zero=1, in_idx=2'bxx -> grant stays 0000, none_pulse=1 for one cycle, in_ready stays 1.
- Timeout: idx=2, done held 0 -> grant=0100 for exactly 15 cycles, then 0000 with timeout=1 for one cycle; in_ready=1 the same cycle.
- Collision: assert done in the same cycle the counter reaches 14 -> grant cleared, timeout=0.
- Reset mid-grant: idx=3 granted, rst pulsed on the 5th cycle -> grant=0000 immediately and no timeout; new accept of idx=1 right after release -> grant=0010 the next cycle.

Source files
------------

// File: rtl/grant_decoder_pkg.sv
// Shared types and defaults for the grant decoder and its one-hot decode stage.
package grant_decoder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam int DEF_N_OUT    = 4;
    localparam int DEF_HOLD_MAX = 15;

endpackage

// File: rtl/grant_decoder_onehot_dec.sv
// Combinational index-to-one-hot decoder with enable.
// When disabled the output is forced to zero regardless of the index value.
module onehot_dec
    import grant_decoder_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int IDX_W = $clog2(DEF_N_OUT)
) (
    input  logic             en_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [N_OUT-1:0] onehot_o
);

    assign onehot_o = en_i ? (N_OUT'(1) << idx_i) : '0;

endmodule

// File: rtl/grant_decoder.sv
// Registered one-hot grant driven from the priority encoder's {index, zero} word.
// A grant is held until done or until HOLD_MAX cycles have elapsed.
module grant_decoder
    import grant_decoder_pkg::*;
#(
    parameter int N_OUT    = DEF_N_OUT,
    parameter int IDX_W    = 2,
    parameter int HOLD_MAX = DEF_HOLD_MAX,
    parameter int CNT_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IDX_W-1:0] in_idx,
    input  logic             in_zero,
    input  logic             done,
    output logic [N_OUT-1:0] grant,
    output logic             grant_valid,
    output logic             none_pulse,
    output logic             timeout
);

    generate
        if (IDX_W != $clog2(N_OUT) || N_OUT < 2) begin : g_bad_idx_w
            $error("grant_decoder: IDX_W must equal log2(N_OUT), N_OUT >= 2");
        end
        if (HOLD_MAX < 1 || (HOLD_MAX - 1) >= (1 << CNT_W)) begin : g_bad_cnt_w
            $error("grant_decoder: HOLD_MAX-1 must fit in CNT_W bits");
        end
    endgenerate

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

    state_e             state_q, state_d;
    logic [N_OUT-1:0]   grant_q, grant_d;
    logic               gvld_q, gvld_d;
    logic               none_q, none_d;
    logic               tout_q, tout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic [N_OUT-1:0]   dec_onehot;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;

    onehot_dec #(.N_OUT(N_OUT), .IDX_W(IDX_W)) u_dec (
        .en_i     (accept & ~in_zero),
        .idx_i    (in_idx),
        .onehot_o (dec_onehot)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gvld_d  = gvld_q;
        cnt_d   = cnt_q;
        none_d  = 1'b0;
        tout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_zero) begin
                        none_d = 1'b1;
                    end else begin
                        grant_d = dec_onehot;
                        gvld_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                // done takes priority over expiry, so a simultaneous release is not a timeout
                if (done || cnt_q == HOLD_LAST) begin
                    grant_d = '0;
                    gvld_d  = 1'b0;
                    cnt_d   = '0;
                    tout_d  = ~done;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gvld_q  <= 1'b0;
            none_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gvld_q  <= gvld_d;
            none_q  <= none_d;
            tout_q  <= tout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gvld_q;
    assign none_pulse  = none_q;
    assign timeout     = tout_q;

endmodule

// File: tb/tb_grant_decoder.sv
// Self-checking bench for grant_decoder: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of grant ownership.
module tb_grant_decoder;

    localparam int N_OUT    = 4;
    localparam int IDX_W    = 2;
    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [IDX_W-1:0] in_idx = '0;
    logic             in_zero = 1'b0;
    logic             done = 1'b0;
    logic [N_OUT-1:0] grant;
    logic             grant_valid;
    logic             none_pulse;
    logic             timeout;

    int tests = 0;
    int fails = 0;

    // Model: who owns the grant and for how many cycles it has been visible.
    bit m_busy;
    int m_line;
    int m_held;
    bit m_none;
    bit m_to;

    grant_decoder #(
        .N_OUT(N_OUT), .IDX_W(IDX_W), .HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_idx      (in_idx),
        .in_zero     (in_zero),
        .done        (done),
        .grant       (grant),
        .grant_valid (grant_valid),
        .none_pulse  (none_pulse),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [N_OUT-1:0] m_grant();
        logic [N_OUT-1:0] g;
        g = '0;
        if (m_busy) g[m_line] = 1'b1;
        return g;
    endfunction

    function automatic logic [N_OUT+3:0] m_outs();
        return {m_grant(), m_busy, m_none, m_to, !m_busy};
    endfunction

    function automatic logic [N_OUT+3:0] dut_outs();
        return {grant, grant_valid, none_pulse, timeout, in_ready};
    endfunction

    task automatic m_reset();
        m_busy = 0; m_line = 0; m_held = 0; m_none = 0; m_to = 0;
    endtask

    // Advance one clock; the model reacts to the inputs seen at the edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) begin
            m_none = 0;
            m_to   = 0;
            if (!m_busy) begin
                if (in_valid) begin
                    if (in_zero) m_none = 1;
                    else begin
                        m_busy = 1; m_line = int'(in_idx); m_held = 1;
                    end
                end
            end else if (done) begin
                m_busy = 0;
            end else if (m_held == HOLD_MAX) begin
                m_busy = 0; m_to = 1;
            end else begin
                m_held++;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        #1;
        tests++;
        if (grant !== 4'b0000 || in_ready !== 1'b1 || timeout !== 1'b0 || grant_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: grant=%b ready=%b timeout=%b gv=%b, want 0000/1/0/0",
                     grant, in_ready, timeout, grant_valid);
        end
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            tests++;
            if (dut_outs() !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1}) begin
                fails++;
                $display("FAIL reset_idle[%0d]: outs=%b want %b", i, dut_outs(),
                         {4'b0000, 1'b0, 1'b0, 1'b0, 1'b1});
            end
        end
    endtask

    task automatic test_decode_all();
        logic [N_OUT-1:0] want;
        for (int idx = 0; idx < N_OUT; idx++) begin
            want = '0;
            want[idx] = 1'b1;
            in_valid = 1'b1; in_zero = 1'b0; in_idx = IDX_W'(idx);
            cycle();
            in_valid = 1'b0;
            for (int c = 1; c <= 3; c++) begin
                tests++;
                if (grant !== want || grant_valid !== 1'b1 || in_ready !== 1'b0 || timeout !== 1'b0) begin
                    fails++;
                    $display("FAIL decode idx%0d cyc%0d: grant=%b gv=%b ready=%b to=%b want %b/1/0/0",
                             idx, c, grant, grant_valid, in_ready, timeout, want);
                end
                if (c == 3) done = 1'b1;
                cycle();
            end
            done = 1'b0;
            tests++;
            if (dut_outs() !== m_outs() || grant !== 4'b0000 || timeout !== 1'b0) begin
                fails++;
                $display("FAIL decode_release idx%0d: outs=%b want %b", idx, dut_outs(), m_outs());
            end
        end
    endtask

    task automatic test_zero_word();
        in_valid = 1'b1; in_zero = 1'b1; in_idx = 'x;
        cycle();
        in_valid = 1'b0; in_zero = 1'b0; in_idx = '0;
        tests++;
        if (grant !== 4'b0000 || none_pulse !== 1'b1 || in_ready !== 1'b1 || m_none != 1) begin
            fails++;
            $display("FAIL zero_word: grant=%b none=%b ready=%b want 0000/1/1", grant, none_pulse, in_ready);
        end
        cycle();
        tests++;
        if (dut_outs() !== m_outs() || none_pulse !== 1'b0) begin
            fails++;
            $display("FAIL zero_word_pulse_end: outs=%b want %b", dut_outs(), m_outs());
        end
    endtask

    task automatic test_timeout();
        int held;
        held = 0;
        in_valid = 1'b1; in_zero = 1'b0; in_idx = 2'd2;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < HOLD_MAX + 5 && grant === 4'b0100; c++) begin
            held++;
            if (timeout !== 1'b0) begin
                tests++; fails++;
                $display("FAIL timeout_early: timeout=1 at grant cycle %0d", held);
            end
            cycle();
        end
        tests++;
        if (held != HOLD_MAX) begin
            fails++;
            $display("FAIL timeout_duration: held %0d cycles, want %0d", held, HOLD_MAX);
        end
        tests++;
        if (grant !== 4'b0000 || timeout !== 1'b1 || in_ready !== 1'b1 || dut_outs() !== m_outs()) begin
            fails++;
            $display("FAIL timeout_pulse: grant=%b to=%b ready=%b want 0000/1/1", grant, timeout, in_ready);
        end
        cycle();
        tests++;
        if (timeout !== 1'b0) begin
            fails++;
            $display("FAIL timeout_one_cycle: timeout=%b want 0", timeout);
        end
    endtask

    task automatic test_collision();
        in_valid = 1'b1; in_zero = 1'b0; in_idx = 2'd1;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < HOLD_MAX - 1; c++) cycle();
        tests++;
        if (grant !== 4'b0010) begin
            fails++;
            $display("FAIL collision_hold: grant=%b want 0010 on last hold cycle", grant);
        end
        done = 1'b1;
        cycle();
        done = 1'b0;
        tests++;
        if (grant !== 4'b0000 || timeout !== 1'b0 || grant_valid !== 1'b0 || dut_outs() !== m_outs()) begin
            fails++;
            $display("FAIL collision: grant=%b to=%b gv=%b want 0000/0/0", grant, timeout, grant_valid);
        end
    endtask

    task automatic test_reset_mid_grant();
        in_valid = 1'b1; in_zero = 1'b0; in_idx = 2'd3;
        cycle();
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        rst = 1'b1;
        #1;
        m_reset();
        tests++;
        if (grant !== 4'b0000 || timeout !== 1'b0 || grant_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_grant: grant=%b to=%b gv=%b ready=%b want 0000/0/0/1",
                     grant, timeout, grant_valid, in_ready);
        end
        #1 rst = 1'b0;
        in_valid = 1'b1; in_zero = 1'b0; in_idx = 2'd1;
        cycle();
        in_valid = 1'b0;
        tests++;
        if (grant !== 4'b0010 || timeout !== 1'b0 || dut_outs() !== m_outs()) begin
            fails++;
            $display("FAIL reaccept_after_reset: grant=%b to=%b want 0010/0", grant, timeout);
        end
        done = 1'b1;
        cycle();
        done = 1'b0;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_zero = 1'b0; in_idx = 2'd0;
            cycle();
            in_valid = 1'b0;
            done = 1'b1;
            tests++;
            if (grant !== 4'b0001 || dut_outs() !== m_outs()) begin
                fails++;
                $display("FAIL back_to_back[%0d]: grant=%b want 0001", k, grant);
            end
            cycle();
            done = 1'b0;
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_zero  = ($urandom_range(0, 3) == 0);
            in_idx   = IDX_W'($urandom_range(0, N_OUT - 1));
            done     = ($urandom_range(0, 9) == 0);
            cycle();
            tests++;
            if (dut_outs() !== m_outs() || $countones(grant) > 1 || grant_valid !== (|grant)) begin
                fails++;
                $display("FAIL random[%0d]: outs{grant,gv,none,to,ready}=%b want %b", c, dut_outs(), m_outs());
            end
        end
        in_valid = 1'b0; done = 1'b0;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_decode_all();
        test_zero_word();
        test_timeout();
        test_collision();
        test_reset_mid_grant();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
